// File: rtl/monitor_arbiter.sv
// Round-robin arbiter sharing the monitor UART transmitter among N_REQ byte producers.
// Optional MONITOR_ARB_HEADER_EN: each grant sends a header frame (HDR_BASE | grant_id) before the data frame.
module monitor_arbiter #(
   parameter int         N_REQ      = 4,
   parameter int         ID_W       = 2,
   parameter int         DIVIDE_P   = 31,
   parameter int         START_HOLD = 2,
   parameter int         GUARD      = 4,
   parameter logic [7:0] HDR_BASE   = 8'hA0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           send_monitor_value,
   output logic                 send_monitor_start,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id
);

   localparam int FRAME_CYCLES = (DIVIDE_P + 1) * 11 + GUARD;
   localparam int TW = $clog2(FRAME_CYCLES + START_HOLD);
   localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LOAD  = TW'(START_HOLD - 1);

   // Header ids are OR-ed into HDR_BASE, so its low ID_W bits must be clear.
   if (N_REQ < 1 || N_REQ > 4 || (1 << ID_W) < N_REQ || START_HOLD < 2 ||
       (int'(HDR_BASE) % (1 << ID_W)) != 0) begin : g_cfg_error
      $error("monitor_arbiter: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT
`ifdef MONITOR_ARB_HEADER_EN
      , S_HDR_WAIT
`endif
   } state_t;

   state_t            state, state_nxt;
   logic [TW-1:0]     timer, timer_nxt;
   logic [7:0]        value_nxt;
   logic              start_nxt, busy_nxt;
   logic [ID_W-1:0]   grant_nxt, rr_ptr, rr_ptr_nxt;
   logic              found;
   logic [ID_W-1:0]   winner, idx, winner_inc;
   logic [7:0]        win_data;
   logic [N_REQ-1:0]  win_vec;
`ifdef MONITOR_ARB_HEADER_EN
   logic [7:0]        data_hold, data_hold_nxt;
   logic              hdr_phase, hdr_phase_nxt;
`endif

   // First valid requester scanning upward from rr_ptr with wrap.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = ID_W'((32'(rr_ptr) + k) % 32'(N_REQ));
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      win_data = '0;
      win_vec  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (32'(winner) == k) begin
            win_data   = req_data[8*k +: 8];
            win_vec[k] = found;
         end
      end
   end

   assign winner_inc = (32'(winner) == 32'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
   assign req_ready  = (state == S_IDLE && !rst) ? win_vec : '0;

   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      value_nxt  = send_monitor_value;
      start_nxt  = send_monitor_start;
      busy_nxt   = busy;
      grant_nxt  = grant_id;
      rr_ptr_nxt = rr_ptr;
`ifdef MONITOR_ARB_HEADER_EN
      data_hold_nxt = data_hold;
      hdr_phase_nxt = hdr_phase;
`endif
      unique case (state)
         S_IDLE: begin
            if (found) begin
               grant_nxt  = winner;
               rr_ptr_nxt = winner_inc;
               busy_nxt   = 1'b1;
               start_nxt  = 1'b1;
               timer_nxt  = HOLD_LOAD;
               state_nxt  = S_START;
`ifdef MONITOR_ARB_HEADER_EN
               value_nxt     = HDR_BASE | 8'(winner);
               data_hold_nxt = win_data;
               hdr_phase_nxt = 1'b1;
`else
               value_nxt     = win_data;
`endif
            end
         end
         S_START: begin
            if (timer == '0) begin
               start_nxt = 1'b0;
               timer_nxt = FRAME_LOAD;
`ifdef MONITOR_ARB_HEADER_EN
               state_nxt = hdr_phase ? S_HDR_WAIT : S_WAIT;
`else
               state_nxt = S_WAIT;
`endif
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         S_WAIT: begin
            if (timer == '0) begin
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
`ifdef MONITOR_ARB_HEADER_EN
         S_HDR_WAIT: begin
            if (timer == '0) begin
               hdr_phase_nxt = 1'b0;
               value_nxt     = data_hold;
               start_nxt     = 1'b1;
               timer_nxt     = HOLD_LOAD;
               state_nxt     = S_START;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= S_IDLE;
         timer              <= '0;
         send_monitor_value <= '0;
         send_monitor_start <= 1'b0;
         busy               <= 1'b0;
         grant_id           <= '0;
         rr_ptr             <= '0;
`ifdef MONITOR_ARB_HEADER_EN
         data_hold          <= '0;
         hdr_phase          <= 1'b0;
`endif
      end else begin
         state              <= state_nxt;
         timer              <= timer_nxt;
         send_monitor_value <= value_nxt;
         send_monitor_start <= start_nxt;
         busy               <= busy_nxt;
         grant_id           <= grant_nxt;
         rr_ptr             <= rr_ptr_nxt;
`ifdef MONITOR_ARB_HEADER_EN
         data_hold          <= data_hold_nxt;
         hdr_phase          <= hdr_phase_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_monitor_arbiter.sv
// Self-checking bench for monitor_arbiter: frame-window reference model checked every cycle,
// a table of single-grant vectors, hand-written corner sequences and a randomized phase.
module tb_monitor_arbiter;

   localparam int N  = 4;
   localparam int SH = 2;
   localparam int FC = (31 + 1) * 11 + 4;
`ifdef MONITOR_ARB_HEADER_EN
   localparam int NF  = 2;
   localparam bit HDR = 1'b1;
`else
   localparam int NF  = 1;
   localparam bit HDR = 1'b0;
`endif
   localparam int TB  = NF * (SH + FC);
   localparam int LIM = 2 * TB + 20;

   logic        clk, rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  send_monitor_value;
   logic        send_monitor_start, busy;
   logic [1:0]  grant_id;

   monitor_arbiter #(
      .N_REQ(4), .ID_W(2), .DIVIDE_P(31), .START_HOLD(2), .GUARD(4), .HDR_BASE(8'hA0)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .send_monitor_value(send_monitor_value),
      .send_monitor_start(send_monitor_start), .busy(busy), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   // reference model state: cycle of last capture and what it captured
   int         cyc = 0, gc = 0, m_ptr = 0, m_gid = 0;
   bit         have = 1'b0;
   logic [7:0] m_first = '0, m_data = '0;
   logic [3:0] last_rdy;
   logic       last_busy, last_start;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int first_valid(logic [3:0] v, int p);
      int i;
      for (int k = 0; k < N; k++) begin
         i = (p + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_cycle();
      int d, w;
      bit in_frame;
      logic [3:0] er;
      logic es;
      logic [7:0] ev;
      if (rst) begin
         have = 1'b0; m_ptr = 0; m_gid = 0; m_first = '0; m_data = '0;
      end
      d = have ? cyc - gc : 32'h3fff_ffff;
      in_frame = have && d >= 1 && d <= TB;
      w = first_valid(req_valid, m_ptr);
      er = '0;
      if (!rst && !in_frame && w >= 0) er[w] = 1'b1;
      es = 1'b0;
      for (int f = 0; f < NF; f++)
         if (have && d > f * (SH + FC) && d <= f * (SH + FC) + SH) es = 1'b1;
      ev = (HDR && d > SH + FC) ? m_data : m_first;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(in_frame));
      chk("start", 32'(send_monitor_start), 32'(es));
      chk("value", 32'(send_monitor_value), 32'(ev));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      last_rdy = req_ready; last_busy = busy; last_start = send_monitor_start;
      if (er != '0) begin
         have    = 1'b1;
         gc      = cyc;
         m_gid   = w;
         m_ptr   = (w + 1) % N;
         m_data  = req_data[8*w +: 8];
         m_first = HDR ? (8'hA0 | 8'(w)) : m_data;
      end
      cyc++;
   endtask

   // inputs are set at the falling edge, checked 1 time unit later, captured at the next rising edge
   task automatic step();
      #1;
      model_cycle();
      @(negedge clk);
   endtask

   task automatic wait_cap(string name);
      bit ok = 1'b0;
      for (int i = 0; i < LIM && !ok; i++) begin
         step();
         if (last_rdy != '0) ok = 1'b1;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(string name);
      bit ok = 1'b0;
      for (int i = 0; i < LIM && !ok; i++) begin
         step();
         if (!last_busy) ok = 1'b1;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      int          gid;
      logic [7:0]  byt;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int cnt, scnt;
      logic [3:0] oh;
      rst = 1'b1; req_valid = '0; req_data = '0;
      @(negedge clk);

      // sequence of grants from rr_ptr=0 after reset
      tbl[0] = '{4'b0001, 32'h0000_0055, 0, 8'h55};
      tbl[1] = '{4'b1111, 32'h1312_1110, 1, 8'h11};
      tbl[2] = '{4'b0011, 32'h0000_BBAA, 0, 8'hAA};
      tbl[3] = '{4'b1000, 32'hC300_0000, 3, 8'hC3};
      tbl[4] = '{4'b0110, 32'h005A_A500, 1, 8'hA5};
      tbl[5] = '{4'b0100, 32'h00E7_0000, 2, 8'hE7};
      tbl[6] = '{4'b0001, 32'h0000_0001, 0, 8'h01};

      step(); step();
      chk("rst_value", 32'(send_monitor_value), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;

      for (int t = 0; t < 7; t++) begin
         req_valid = tbl[t].v;
         req_data  = tbl[t].d;
         wait_cap("tbl_capture");
         oh = '0; oh[tbl[t].gid] = 1'b1;
         chk("tbl_ready", 32'(last_rdy), 32'(oh));
         chk("tbl_gid", 32'(grant_id), 32'(tbl[t].gid));
         req_valid = '0;
         cnt = 0; scnt = 0;
         for (int i = 0; i < LIM; i++) begin
            step();
            if (!last_busy) break;
            cnt++;
            if (last_start) scnt++;
         end
         chk("tbl_busy_len", 32'(cnt), 32'(TB));
         chk("tbl_start_len", 32'(scnt), 32'(NF * SH));
         chk("tbl_value", 32'(send_monitor_value), 32'(tbl[t].byt));
      end

      // all four held: strict rotation 0,1,2,3,0
      do_reset();
      req_valid = 4'b1111; req_data = 32'h1312_1110;
      for (int g = 0; g < 5; g++) begin
         wait_cap("rr_capture");
         chk("rr_gid", 32'(grant_id), 32'(g % 4));
      end
      req_valid = '0;
      wait_idle("rr_idle");
      chk("rr_last_value", 32'(send_monitor_value), 32'h10);

      // ch1 held, ch3 joins mid-frame: 1 then 3,1,3
      req_valid = 4'b0010; req_data = 32'h2300_2100;
      wait_cap("alt_capture");
      chk("alt_first", 32'(grant_id), 32'd1);
      for (int i = 0; i < 20; i++) step();
      req_valid = 4'b1010;
      for (int g = 0; g < 3; g++) begin
         wait_cap("alt_capture");
         chk("alt_gid", 32'(grant_id), (g % 2 == 0) ? 32'd3 : 32'd1);
      end
      req_valid = '0;
      wait_idle("alt_idle");

      // data change during WAIT must not disturb the held value
      req_valid = 4'b0001; req_data = 32'h0000_0055;
      wait_cap("hold_capture");
      req_valid = '0;
      for (int i = 0; i < 50; i++) step();
      req_data = 32'h0000_00FF;
      for (int i = 0; i < 100; i++) step();
      chk("hold_mid", 32'(send_monitor_value), HDR ? 32'hA0 : 32'h55);
      wait_idle("hold_idle");
      chk("hold_end", 32'(send_monitor_value), 32'h55);

      // reset in WAIT at timer=100, then restart from rr_ptr=0
      req_valid = 4'b0001; req_data = 32'h0000_0077;
      wait_cap("rst_capture");
      req_valid = '0;
      for (int i = 1; i < SH + FC - 100; i++) step();
      rst = 1'b1; req_valid = 4'b0100; req_data = 32'h0099_0000;
      step();
      chk("rstmid_start", 32'(send_monitor_start), 32'h0);
      chk("rstmid_busy", 32'(busy), 32'h0);
      chk("rstmid_value", 32'(send_monitor_value), 32'h0);
      chk("rstmid_ready", 32'(req_ready), 32'h0);
      rst = 1'b0;
      wait_cap("rst_regrant");
      chk("rst_regrant_gid", 32'(grant_id), 32'd2);
      req_valid = '0;
      wait_idle("rst_idle");

      // ch2 byte 0x3C: header 0xA2 first when enabled
      req_valid = 4'b0100; req_data = 32'h003C_0000;
      wait_cap("hdr_capture");
      req_valid = '0;
      chk("hdr_first", 32'(send_monitor_value), HDR ? 32'hA2 : 32'h3C);
      cnt = 1;
      for (int i = 0; i < LIM; i++) begin
         step();
         if (!last_busy) break;
         cnt++;
      end
      chk("hdr_busy_len", 32'(cnt), 32'(TB + 1));
      chk("hdr_data", 32'(send_monitor_value), 32'h3C);

      // randomized traffic against the model
      for (int i = 0; i < 9000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
